// File: rtl/object_rect_animator_pkg.sv
// Shared definitions for the animated rectangle object: default VGA active
// area, internal coordinate width and the display-mode encodings.
package object_rect_animator_pkg;

    localparam int H_ACTIVE_DEFAULT = 640;
    localparam int V_ACTIVE_DEFAULT = 480;

    // Position and extent arithmetic is done one bit wider than the counters
    // so that x + OBJ_W - 1 never wraps.
    localparam int POS_W = 11;

    typedef enum logic [1:0] {
        MODE_STATIC_TOP    = 2'd0,
        MODE_STATIC_CENTER = 2'd1,
        MODE_HIDDEN        = 2'd2,
        MODE_BOUNCE        = 2'd3
    } mode_t;

endpackage

// File: rtl/object_rect_animator_vga_frame_tick.sv
// One-clock frame pulse generator. Fires once when the sync counters first
// reach the start of vertical blanking, however long they dwell there.
module vga_frame_tick #(
    parameter int V_ACTIVE = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] HCount,
    input  logic [9:0] VCount,
    output logic       frame_tick
);

    logic cond;
    logic cond_q;

    // Start-of-blanking detect: first pixel of the first non-visible line.
    always_comb begin
        cond = (HCount == 10'd0) && (VCount == 10'(V_ACTIVE));
    end

    // Rising-edge detect of the blanking condition, registered as the pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            cond_q     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            cond_q     <= cond;
            frame_tick <= cond & ~cond_q;
        end
    end

endmodule

// File: rtl/object_rect_animator.sv
// Rectangle object for the VGA pipeline: static top/centre layouts, a hidden
// mode, and a bouncing animation that advances once per frame. The pixel-on
// decision and colour are registered, one clock behind the counters.
module object_rect_animator
    import object_rect_animator_pkg::*;
#(
    parameter int         H_ACTIVE = H_ACTIVE_DEFAULT,
    parameter int         V_ACTIVE = V_ACTIVE_DEFAULT,
    parameter int         OBJ_W    = 110,
    parameter int         OBJ_H    = 110,
    parameter int         X_HOME   = 264,
    parameter int         Y_TOP    = 48,
    parameter int         Y_CENTER = 182,
    parameter int         STEP     = 2,
    parameter logic [7:0] COLOR    = 8'hE0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] HCount,
    input  logic [9:0] VCount,
    input  logic       square_select,
    input  logic       full_screen,
    input  logic       move_en,
    output logic       obj_on,
    output logic [7:0] obj_rgb,
    output logic       frame_tick
);

    localparam logic [POS_W-1:0] X_MAX    = POS_W'(H_ACTIVE - OBJ_W);
    localparam logic [POS_W-1:0] Y_MAX    = POS_W'(V_ACTIVE - OBJ_H);
    localparam logic [POS_W-1:0] STEP_P   = POS_W'(STEP);
    localparam logic [POS_W-1:0] X_HOME_P = POS_W'(X_HOME);
    localparam logic [POS_W-1:0] Y_TOP_P  = POS_W'(Y_TOP);
    localparam logic [POS_W-1:0] Y_CEN_P  = POS_W'(Y_CENTER);
    localparam logic [POS_W-1:0] W_M1     = POS_W'(OBJ_W - 1);
    localparam logic [POS_W-1:0] H_M1     = POS_W'(OBJ_H - 1);

    mode_t            mode, mode_next;
    logic [POS_W-1:0] x, x_next;
    logic [POS_W-1:0] y, y_next;
    logic             dx_pos, dx_pos_next;
    logic             dy_pos, dy_pos_next;
    logic [POS_W-1:0] x_r, y_b;
    logic [POS_W-1:0] h_pos, v_pos;
    logic             obj_on_d;

    vga_frame_tick #(
        .V_ACTIVE (V_ACTIVE)
    ) u_frame_tick (
        .clk        (clk),
        .reset      (reset),
        .HCount     (HCount),
        .VCount     (VCount),
        .frame_tick (frame_tick)
    );

    // Mode, position and direction registers; everything moves only on a tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode   <= MODE_STATIC_TOP;
            x      <= X_HOME_P;
            y      <= Y_TOP_P;
            dx_pos <= 1'b1;
            dy_pos <= 1'b1;
        end else begin
            mode   <= mode_next;
            x      <= x_next;
            y      <= y_next;
            dx_pos <= dx_pos_next;
            dy_pos <= dy_pos_next;
        end
    end

    // Next mode from the layout inputs, and the position that goes with it.
    // The first tick in BOUNCE only arms the directions; later ticks move.
    always_comb begin
        mode_next   = mode;
        x_next      = x;
        y_next      = y;
        dx_pos_next = dx_pos;
        dy_pos_next = dy_pos;
        if (frame_tick) begin
            if (full_screen) begin
                mode_next = square_select ? MODE_STATIC_CENTER : MODE_HIDDEN;
            end else begin
                mode_next = move_en ? MODE_BOUNCE : MODE_STATIC_TOP;
            end
            case (mode_next)
                MODE_STATIC_TOP: begin
                    x_next = X_HOME_P;
                    y_next = Y_TOP_P;
                end
                MODE_STATIC_CENTER: begin
                    x_next = X_HOME_P;
                    y_next = Y_CEN_P;
                end
                MODE_BOUNCE: begin
                    if (mode != MODE_BOUNCE) begin
                        dx_pos_next = 1'b1;
                        dy_pos_next = 1'b1;
                    end else begin
                        if (dx_pos) begin
                            if (x + STEP_P > X_MAX) begin
                                x_next      = X_MAX;
                                dx_pos_next = 1'b0;
                            end else begin
                                x_next = x + STEP_P;
                            end
                        end else begin
                            if (x < STEP_P) begin
                                x_next      = '0;
                                dx_pos_next = 1'b1;
                            end else begin
                                x_next = x - STEP_P;
                            end
                        end
                        if (dy_pos) begin
                            if (y + STEP_P > Y_MAX) begin
                                y_next      = Y_MAX;
                                dy_pos_next = 1'b0;
                            end else begin
                                y_next = y + STEP_P;
                            end
                        end else begin
                            if (y < STEP_P) begin
                                y_next      = '0;
                                dy_pos_next = 1'b1;
                            end else begin
                                y_next = y - STEP_P;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Inclusive hit test against the currently registered position.
    always_comb begin
        h_pos    = {1'b0, HCount};
        v_pos    = {1'b0, VCount};
        x_r      = x + W_M1;
        y_b      = y + H_M1;
        obj_on_d = (mode != MODE_HIDDEN) &&
                   (h_pos >= x) && (h_pos <= x_r) &&
                   (v_pos >= y) && (v_pos <= y_b);
    end

    // Registered pixel decision and colour, kept aligned with each other.
    always_ff @(posedge clk) begin
        if (reset) begin
            obj_on  <= 1'b0;
            obj_rgb <= 8'h00;
        end else begin
            obj_on  <= obj_on_d;
            obj_rgb <= obj_on_d ? COLOR : 8'h00;
        end
    end

endmodule

// File: tb/tb_object_rect_animator.sv
// Self-checking bench for object_rect_animator: a frame-level model of the
// rectangle's mode and position predicts every probed pixel.
module tb_object_rect_animator;

    localparam int W = 110;
    localparam int H = 110;
    localparam int XMAX = 640 - W;
    localparam int YMAX = 480 - H;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] HCount;
    logic [9:0] VCount;
    logic       square_select;
    logic       full_screen;
    logic       move_en;
    logic       obj_on;
    logic [7:0] obj_rgb;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 top, 1 centre, 2 hidden, 3 bounce
    int m_mode, m_x, m_y, m_dx, m_dy;

    object_rect_animator dut (
        .clk           (clk),
        .reset         (reset),
        .HCount        (HCount),
        .VCount        (VCount),
        .square_select (square_select),
        .full_screen   (full_screen),
        .move_en       (move_en),
        .obj_on        (obj_on),
        .obj_rgb       (obj_rgb),
        .frame_tick    (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = 0; m_x = 264; m_y = 48; m_dx = 1; m_dy = 1;
    endtask

    // What a frame boundary does to the model, given the current inputs.
    task automatic model_frame();
        int nm;
        if (full_screen) nm = square_select ? 1 : 2;
        else             nm = move_en ? 3 : 0;
        if (nm == 0) begin m_x = 264; m_y = 48; end
        else if (nm == 1) begin m_x = 264; m_y = 182; end
        else if (nm == 3) begin
            if (m_mode != 3) begin
                m_dx = 1; m_dy = 1;
            end else begin
                m_x = m_x + 2 * m_dx;
                if (m_x > XMAX) begin m_x = XMAX; m_dx = -1; end
                if (m_x < 0)    begin m_x = 0;    m_dx = 1;  end
                m_y = m_y + 2 * m_dy;
                if (m_y > YMAX) begin m_y = YMAX; m_dy = -1; end
                if (m_y < 0)    begin m_y = 0;    m_dy = 1;  end
            end
        end
        m_mode = nm;
    endtask

    function automatic bit model_hit(int h, int v);
        return (m_mode != 2) && h >= m_x && h < m_x + W && v >= m_y && v < m_y + H;
    endfunction

    // Present one pixel and compare the registered result one clock later.
    task automatic probe(int h, int v, string name);
        bit exp_on;
        logic [7:0] exp_rgb;
        if (h < 0 || h > 1023 || v < 0 || v > 479) return;
        @(negedge clk);
        HCount = 10'(h); VCount = 10'(v);
        @(posedge clk); #1;
        exp_on  = model_hit(h, v);
        exp_rgb = exp_on ? 8'hE0 : 8'h00;
        checks++;
        if (obj_on !== exp_on || obj_rgb !== exp_rgb || frame_tick !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s (%0d,%0d): obj_on=%b rgb=%h tick=%b, expected obj_on=%b rgb=%h tick=0",
                     name, h, v, obj_on, obj_rgb, frame_tick, exp_on, exp_rgb);
        end
    endtask

    // Hold the counters at start of blanking for a while; expect one pulse.
    task automatic do_frame(int hold);
        int pulses = 0;
        @(negedge clk);
        HCount = 10'd0; VCount = 10'd480;
        repeat (hold) begin
            @(posedge clk); #1;
            if (frame_tick === 1'b1) pulses++;
        end
        @(negedge clk);
        HCount = 10'd5;
        repeat (3) begin
            @(posedge clk); #1;
            if (frame_tick === 1'b1) pulses++;
        end
        model_frame();
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("[TB] FAIL frame_tick_count: got %0d pulses, expected 1", pulses);
        end
    endtask

    task automatic probe_edges(string name);
        probe(m_x, m_y, {name, "_tl"});
        probe(m_x - 1, m_y, {name, "_left"});
        probe(m_x, m_y - 1, {name, "_above"});
        probe(m_x + W - 1, m_y + H - 1, {name, "_br"});
        probe(m_x + W, m_y + H - 1, {name, "_right"});
        probe(m_x + W - 1, m_y + H, {name, "_below"});
    endtask

    task automatic test_reset();
        reset = 1'b1; HCount = 10'd300; VCount = 10'd100;
        square_select = 1'b0; full_screen = 1'b0; move_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obj_on !== 1'b0 || obj_rgb !== 8'h00 || frame_tick !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: obj_on=%b rgb=%h tick=%b, expected 0/00/0",
                     obj_on, obj_rgb, frame_tick);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_static_top();
        probe(264, 48, "top_tl");
        probe(373, 157, "top_br");
        probe(263, 48, "top_left_out");
        probe(374, 48, "top_right_out");
        do_frame(1);
        probe_edges("top_frame");
    endtask

    task automatic test_full_screen();
        @(negedge clk);
        full_screen = 1'b1; square_select = 1'b1;
        probe(264, 48, "fs_midframe_old");
        probe(264, 182, "fs_midframe_new");
        do_frame(2);
        probe(264, 182, "fs_center_on");
        probe(264, 48, "fs_top_off");
        probe_edges("fs_center");
        square_select = 1'b0;
        do_frame(3);
        for (int i = 0; i < 6; i++)
            probe(264 + 20 * i, 182 + 15 * i, "fs_hidden");
        full_screen = 1'b0;
        do_frame(1);
        probe_edges("back_to_top");
    endtask

    task automatic test_frame_tick_hold();
        for (int hold = 1; hold <= 5; hold++) do_frame(hold);
        do_frame(4);
    endtask

    task automatic test_bounce();
        move_en = 1'b1;
        do_frame(4);
        probe_edges("bounce_enter");
        do_frame(4);
        probe(266, 50, "bounce_first_step");
        probe(265, 50, "bounce_first_left");
        probe(266, 49, "bounce_first_above");
        for (int f = 0; f < 200; f++) begin
            do_frame(1 + f % 3);
            probe_edges("bounce_run");
        end
    endtask

    task automatic test_reset_mid_bounce();
        probe(m_x, m_y, "pre_reset_inside");
        @(negedge clk);
        HCount = 10'(m_x); VCount = 10'(m_y);
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (obj_on !== 1'b0 || obj_rgb !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_mid_bounce: obj_on=%b rgb=%h, expected 0/00", obj_on, obj_rgb);
        end
        @(negedge clk);
        reset = 1'b0; move_en = 1'b0;
        model_reset();
        probe_edges("after_reset");
        do_frame(2);
        probe_edges("after_reset_frame");
    endtask

    task automatic test_random();
        for (int f = 0; f < 150; f++) begin
            full_screen   = ($urandom_range(0, 3) == 0);
            square_select = $urandom_range(0, 1);
            move_en       = ($urandom_range(0, 3) != 0);
            do_frame($urandom_range(1, 5));
            probe_edges("rand_edge");
            for (int p = 0; p < 4; p++)
                probe($urandom_range(0, 639), $urandom_range(0, 479), "rand_pixel");
        end
    endtask

    initial begin
        test_reset();
        test_static_top();
        test_full_screen();
        test_frame_tick_hold();
        test_bounce();
        test_reset_mid_bounce();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
